// File: rtl/parking_slot_manager_if.sv
// rtl/parking_slot_manager_if.sv - gate sensor requests and occupancy/gate outputs of the slot manager
interface parking_slot_manager_if #(
  parameter int SLOT_W = 3
);
  localparam int SLOTS = 2 ** SLOT_W;

  logic              entry_req;
  logic              exit_req;
  logic [SLOT_W-1:0] exit_slot;
  logic [SLOTS-1:0]  occupancy;
  logic [SLOT_W:0]   free_count;
  logic              full;
  logic              entry_gate;
  logic              exit_gate;
  logic [SLOT_W-1:0] assigned_slot;
  logic              assign_valid;
  logic              exit_err;

  // master is the slot manager (writer of occupancy); slave is the sensor/display side
  modport master (
    input  entry_req, exit_req, exit_slot,
    output occupancy, free_count, full, entry_gate, exit_gate,
    output assigned_slot, assign_valid, exit_err
  );

  modport slave (
    output entry_req, exit_req, exit_slot,
    input  occupancy, free_count, full, entry_gate, exit_gate,
    input  assigned_slot, assign_valid, exit_err
  );
endinterface

// File: rtl/parking_slot_manager.sv
// rtl/parking_slot_manager.sv - allocates lowest free slot on entry, frees named slot on exit, times gate pulses
module parking_slot_manager #(
  parameter int SLOT_W      = 3,
  parameter int GATE_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  parking_slot_manager_if.master bus
);
  localparam int SLOTS = 2 ** SLOT_W;

  typedef enum logic [1:0] {IDLE, ENTRY_OPEN, EXIT_OPEN} state_t;

  state_t            state_q, state_d;
  logic [7:0]        timer_q, timer_d;
  logic              entry_prev_q, exit_prev_q;
  logic              entry_pend_q, entry_pend_d;
  logic              exit_pend_q, exit_pend_d;
  logic [SLOT_W-1:0] exit_slot_q, exit_slot_d;
  logic [SLOTS-1:0]  occ_q, occ_d;
  logic [SLOT_W:0]   free_q, free_d;
  logic              full_q, full_d;
  logic              entry_gate_q, entry_gate_d;
  logic              exit_gate_q, exit_gate_d;
  logic [SLOT_W-1:0] assigned_q, assigned_d;
  logic              assign_valid_q, assign_valid_d;
  logic              exit_err_q, exit_err_d;

  logic              entry_edge, exit_edge;
  logic              entry_want, exit_want;
  logic [SLOT_W-1:0] exit_target;
  logic [SLOT_W-1:0] lowest_free;
  logic [SLOT_W:0]   ones;

  assign entry_edge  = bus.entry_req & ~entry_prev_q;
  assign exit_edge   = bus.exit_req & ~exit_prev_q;
  assign entry_want  = entry_pend_q | entry_edge;
  assign exit_want   = exit_pend_q | exit_edge;
  // a latched exit keeps its captured slot; a fresh edge uses the live slot input
  assign exit_target = exit_pend_q ? exit_slot_q : bus.exit_slot;

  always_comb begin
    lowest_free = '0;
    for (int i = SLOTS - 1; i >= 0; i--) begin
      if (!occ_q[i]) lowest_free = SLOT_W'(i);
    end
  end

  always_comb begin
    state_d        = state_q;
    timer_d        = timer_q;
    occ_d          = occ_q;
    entry_gate_d   = entry_gate_q;
    exit_gate_d    = exit_gate_q;
    assigned_d     = assigned_q;
    assign_valid_d = 1'b0;
    exit_err_d     = 1'b0;
    entry_pend_d   = entry_want;
    exit_pend_d    = exit_want;
    exit_slot_d    = (exit_edge && !exit_pend_q) ? bus.exit_slot : exit_slot_q;

    unique case (state_q)
      IDLE: begin
        if (exit_want) begin
          exit_pend_d = 1'b0;
          if (occ_q[exit_target]) begin
            occ_d[exit_target] = 1'b0;
            exit_gate_d        = 1'b1;
            timer_d            = 8'(GATE_CYCLES);
            state_d            = EXIT_OPEN;
          end else begin
            exit_err_d = 1'b1;
          end
        end else if (entry_want) begin
          entry_pend_d = 1'b0;
          if (!full_q) begin
            occ_d[lowest_free] = 1'b1;
            assigned_d         = lowest_free;
            assign_valid_d     = 1'b1;
            entry_gate_d       = 1'b1;
            timer_d            = 8'(GATE_CYCLES);
            state_d            = ENTRY_OPEN;
          end
        end
      end
      ENTRY_OPEN, EXIT_OPEN: begin
        if (timer_q == 8'd1) begin
          entry_gate_d = 1'b0;
          exit_gate_d  = 1'b0;
          state_d      = IDLE;
        end else begin
          timer_d = timer_q - 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // free_count tracks the next occupancy so it updates on the same edge
  always_comb begin
    ones = '0;
    for (int i = 0; i < SLOTS; i++) begin
      ones = ones + (SLOT_W+1)'(occ_d[i]);
    end
    free_d = (SLOT_W+1)'(SLOTS) - ones;
    full_d = (free_d == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      timer_q        <= '0;
      entry_prev_q   <= 1'b0;
      exit_prev_q    <= 1'b0;
      entry_pend_q   <= 1'b0;
      exit_pend_q    <= 1'b0;
      exit_slot_q    <= '0;
      occ_q          <= '0;
      free_q         <= (SLOT_W+1)'(SLOTS);
      full_q         <= 1'b0;
      entry_gate_q   <= 1'b0;
      exit_gate_q    <= 1'b0;
      assigned_q     <= '0;
      assign_valid_q <= 1'b0;
      exit_err_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      timer_q        <= timer_d;
      entry_prev_q   <= bus.entry_req;
      exit_prev_q    <= bus.exit_req;
      entry_pend_q   <= entry_pend_d;
      exit_pend_q    <= exit_pend_d;
      exit_slot_q    <= exit_slot_d;
      occ_q          <= occ_d;
      free_q         <= free_d;
      full_q         <= full_d;
      entry_gate_q   <= entry_gate_d;
      exit_gate_q    <= exit_gate_d;
      assigned_q     <= assigned_d;
      assign_valid_q <= assign_valid_d;
      exit_err_q     <= exit_err_d;
    end
  end

  assign bus.occupancy     = occ_q;
  assign bus.free_count    = free_q;
  assign bus.full          = full_q;
  assign bus.entry_gate    = entry_gate_q;
  assign bus.exit_gate     = exit_gate_q;
  assign bus.assigned_slot = assigned_q;
  assign bus.assign_valid  = assign_valid_q;
  assign bus.exit_err      = exit_err_q;
endmodule
